// File: rtl/axis_snapshot_pkg.sv
// Shared definitions for the AXI-Stream snapshot buffer: FSM state encoding
// and default parameter values.
package axis_snapshot_pkg;

    localparam int unsigned STATE_W         = 2;
    localparam int unsigned DEF_TDATA_WIDTH = 32;
    localparam int unsigned DEF_DEPTH_LOG2  = 6;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

endpackage

// File: rtl/axis_snapshot_ram.sv
// Simple dual-port capture memory: synchronous write, registered read.
// The read register only updates on rd_en, so it doubles as a holding stage
// for the readout pipeline.
module axis_snapshot_ram
    import axis_snapshot_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_TDATA_WIDTH,
    parameter int unsigned ADDR_W = DEF_DEPTH_LOG2
) (
    input  logic              aclk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, holds its value while rd_en is low
    always_ff @(posedge aclk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_snapshot_buf.sv
// AXI-Stream snapshot buffer: arm, wait for a qualified trigger beat, capture
// DEPTH consecutive valid beats into RAM, then replay them on the m_axis
// stream with tlast on the final beat.
// Optional feature macro: AXIS_SNAPSHOT_PRETRIG_EN -- while armed, every
// valid beat is written circularly so the capture window can start
// cfg_pretrig beats before the trigger.
module axis_snapshot_buf
    import axis_snapshot_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int unsigned DEPTH_LOG2       = DEF_DEPTH_LOG2
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_arm,
    input  logic [DEPTH_LOG2-1:0]       cfg_pretrig,
    input  logic                        trig_flag,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [STATE_W-1:0]          sts_state,
    output logic [AXIS_TDATA_WIDTH-1:0] sts_first
);

    localparam int unsigned DW    = AXIS_TDATA_WIDTH;
    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] wptr;      // next capture write address
    logic [AW-1:0] count;     // beats held in RAM for the current window
    logic [AW-1:0] rd_ptr;    // start address of the window, then read address
    logic [AW-1:0] rd_cnt;    // RAM reads issued during readout
    logic [AW-1:0] out_cnt;   // beats moved into the output register
    logic          rd_done;   // all DEPTH reads issued
    logic          ram_vld;   // RAM read register holds an unconsumed sample

`ifdef AXIS_SNAPSHOT_PRETRIG_EN
    logic [AW-1:0] since_arm; // valid beats written since arming (saturating)
`else
    logic          pretrig_unused;
    assign pretrig_unused = ^cfg_pretrig;
`endif

    logic          trig_hit;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          out_free;
    logic          adv;
    logic          rd_issue;
    logic [DW-1:0] ram_rdata;

    assign s_axis_tready = 1'b1;
    assign sts_state     = state;

    // Trigger qualification and RAM write-port control
    always_comb begin
        trig_hit = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = wptr;
        case (state)
            ST_ARMED: begin
`ifdef AXIS_SNAPSHOT_PRETRIG_EN
                trig_hit = s_axis_tvalid && trig_flag && (since_arm >= cfg_pretrig);
                wr_en    = s_axis_tvalid;
                wr_addr  = wptr;
`else
                trig_hit = s_axis_tvalid && trig_flag;
                wr_en    = trig_hit;
                wr_addr  = '0;
`endif
            end
            ST_CAPTURE: begin
                wr_en   = s_axis_tvalid;
                wr_addr = wptr;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // Readout pipeline handshakes: RAM read register feeds the output register
    always_comb begin
        out_free = !m_axis_tvalid || m_axis_tready;
        adv      = ram_vld && out_free;
        rd_issue = (state == ST_READOUT) && !rd_done && (!ram_vld || out_free);
    end

    axis_snapshot_ram #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) u_ram (
        .aclk    (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (s_axis_tdata),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (ram_rdata)
    );

    // Control FSM with capture counters and registered readout outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            wptr          <= '0;
            count         <= '0;
            rd_ptr        <= '0;
            rd_cnt        <= '0;
            out_cnt       <= '0;
            rd_done       <= 1'b0;
            ram_vld       <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            sts_first     <= '0;
`ifdef AXIS_SNAPSHOT_PRETRIG_EN
            since_arm     <= '0;
`endif
        end else begin
            if (state != ST_READOUT) begin
                rd_cnt  <= '0;
                out_cnt <= '0;
                rd_done <= 1'b0;
                ram_vld <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (cfg_arm) begin
                        state <= ST_ARMED;
                        wptr  <= '0;
`ifdef AXIS_SNAPSHOT_PRETRIG_EN
                        since_arm <= '0;
`endif
                    end
                end
                ST_ARMED: begin
`ifdef AXIS_SNAPSHOT_PRETRIG_EN
                    if (s_axis_tvalid) begin
                        wptr <= wptr + AW'(1);
                        if (since_arm != LAST_IDX) begin
                            since_arm <= since_arm + AW'(1);
                        end
                    end
                    if (trig_hit) begin
                        sts_first <= s_axis_tdata;
                        rd_ptr    <= wptr - cfg_pretrig;
                        count     <= cfg_pretrig + AW'(1);
                        // A full pre-trigger window is already complete
                        if (cfg_pretrig == LAST_IDX) begin
                            state <= ST_READOUT;
                        end else begin
                            state <= ST_CAPTURE;
                        end
                    end
`else
                    if (trig_hit) begin
                        sts_first <= s_axis_tdata;
                        rd_ptr    <= '0;
                        wptr      <= AW'(1);
                        count     <= AW'(1);
                        state     <= ST_CAPTURE;
                    end
`endif
                end
                ST_CAPTURE: begin
                    if (s_axis_tvalid) begin
                        wptr  <= wptr + AW'(1);
                        count <= count + AW'(1);
                        if (count == LAST_IDX) begin
                            state <= ST_READOUT;
                        end
                    end
                end
                ST_READOUT: begin
                    if (rd_issue) begin
                        rd_ptr <= rd_ptr + AW'(1);
                        rd_cnt <= rd_cnt + AW'(1);
                        if (rd_cnt == LAST_IDX) begin
                            rd_done <= 1'b1;
                        end
                    end
                    if (rd_issue) begin
                        ram_vld <= 1'b1;
                    end else if (adv) begin
                        ram_vld <= 1'b0;
                    end
                    if (adv) begin
                        m_axis_tdata  <= ram_rdata;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (out_cnt == LAST_IDX);
                        out_cnt       <= out_cnt + AW'(1);
                    end else if (m_axis_tvalid && m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        if (m_axis_tlast) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_snapshot_buf.sv
// Directed testbench for axis_snapshot_buf with DEPTH_LOG2=3 (8-beat window).
`timescale 1ns/1ps
module tb_axis_snapshot_buf;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 3;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cfg_arm = 1'b0;
    logic [AW-1:0] cfg_pretrig = 3'd5;
    logic          trig_flag = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [1:0]    sts_state;
    logic [DW-1:0] sts_first;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [DW-1:0] rx_data [16];
    int rx_n, rx_last_cnt, rx_last_idx, rx_stall_bad, rx_first_cyc, rx_last_cyc;
    bit rx_timeout;

    axis_snapshot_buf #(
        .AXIS_TDATA_WIDTH (DW),
        .DEPTH_LOG2       (AW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_arm       (cfg_arm),
        .cfg_pretrig   (cfg_pretrig),
        .trig_flag     (trig_flag),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .sts_state     (sts_state),
        .sts_first     (sts_first)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic arm();
        cfg_arm = 1'b1;
        tick();
        cfg_arm = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit t, input int gap);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        trig_flag     = t;
        tick();
        s_axis_tvalid = 1'b0;
        trig_flag     = 1'b0;
        repeat (gap) tick();
    endtask

    // Collects up to max_beats readout beats, recording data, tlast and stall stability
    task automatic collect(input bit rand_ready, input int max_beats);
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic          prev_last = 1'b0;
        logic          rdy;
        rx_n = 0; rx_last_cnt = 0; rx_last_idx = -1; rx_stall_bad = 0;
        rx_first_cyc = 0; rx_last_cyc = 0; rx_timeout = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
                rx_stall_bad++;
            rdy = rand_ready ? logic'($urandom_range(0, 1)) : 1'b1;
            m_axis_tready = rdy;
            if (m_axis_tvalid && rdy && rx_n < 16) begin
                if (rx_n == 0) rx_first_cyc = cyc;
                rx_last_cyc = cyc;
                rx_data[rx_n] = m_axis_tdata;
                if (m_axis_tlast) begin
                    rx_last_cnt++;
                    rx_last_idx = rx_n;
                end
                rx_n++;
            end
            prev_stall = m_axis_tvalid && !rdy;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            tick();
            if (rx_n >= max_beats) break;
        end
        if (rx_n < max_beats) rx_timeout = 1'b1;
        m_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total++; if (sts_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", sts_state); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%0b exp=0", m_axis_tvalid); end
        total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%0b exp=0", m_axis_tlast); end
        total++; if (m_axis_tdata !== 32'd0) begin bad++; $display("FAIL reset_tdata got=%0d exp=0", m_axis_tdata); end
        total++; if (sts_first !== 32'd0) begin bad++; $display("FAIL reset_first got=%0d exp=0", sts_first); end
        total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL reset_tready got=%0b exp=1", s_axis_tready); end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        arm();
        total++; if (sts_state !== 2'd1) begin bad++; $display("FAIL basic_armed got=%0d exp=1", sts_state); end
        for (int i = 0; i < 13; i++) begin
            send(32'(100 + i), (i == 5), 0);
            if (i == 4) begin
                total++; if (sts_state !== 2'd1) begin bad++; $display("FAIL basic_pre_trig got=%0d exp=1", sts_state); end
            end
            if (i == 5) begin
                total++; if (sts_first !== 32'd105) begin bad++; $display("FAIL basic_first got=%0d exp=105", sts_first); end
                total++; if (sts_state !== 2'd2) begin bad++; $display("FAIL basic_capture got=%0d exp=2", sts_state); end
            end
        end
        total++; if (sts_state !== 2'd3) begin bad++; $display("FAIL basic_readout got=%0d exp=3", sts_state); end
        collect(1'b0, 8);
        total++; if (rx_timeout) begin bad++; $display("FAIL basic_timeout got=%0d beats exp=8", rx_n); end
        for (int i = 0; i < 8; i++) begin
            total++; if (rx_data[i] !== 32'(105 + i)) begin bad++; $display("FAIL basic_beat%0d got=%0d exp=%0d", i, rx_data[i], 105 + i); end
        end
        total++; if (rx_last_cnt !== 1 || rx_last_idx !== 7) begin bad++; $display("FAIL basic_tlast got cnt=%0d idx=%0d exp cnt=1 idx=7", rx_last_cnt, rx_last_idx); end
        total++; if (rx_last_cyc - rx_first_cyc !== 7) begin bad++; $display("FAIL basic_rate got=%0d cycles exp=7", rx_last_cyc - rx_first_cyc); end
        total++; if (sts_state !== 2'd0) begin bad++; $display("FAIL basic_idle got=%0d exp=0", sts_state); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL basic_tvalid_end got=%0b exp=0", m_axis_tvalid); end
    endtask

    task automatic test_gapped();
        arm();
        s_axis_tdata = 32'd999; s_axis_tvalid = 1'b0; trig_flag = 1'b1;
        tick();
        trig_flag = 1'b0;
        total++; if (sts_state !== 2'd1) begin bad++; $display("FAIL gap_invalid_trig got=%0d exp=1", sts_state); end
        send(32'd200, 1'b1, 1);
        for (int i = 1; i < 8; i++) send(32'(200 + i), 1'b0, 1);
        total++; if (sts_first !== 32'd200) begin bad++; $display("FAIL gap_first got=%0d exp=200", sts_first); end
        collect(1'b0, 8);
        total++; if (rx_timeout) begin bad++; $display("FAIL gap_timeout got=%0d beats exp=8", rx_n); end
        for (int i = 0; i < 8; i++) begin
            total++; if (rx_data[i] !== 32'(200 + i)) begin bad++; $display("FAIL gap_beat%0d got=%0d exp=%0d", i, rx_data[i], 200 + i); end
        end
        total++; if (sts_state !== 2'd0) begin bad++; $display("FAIL gap_idle got=%0d exp=0", sts_state); end
    endtask

    task automatic test_backpressure();
        arm();
        for (int i = 0; i < 8; i++) send(32'(300 + i), (i == 0), 0);
        collect(1'b1, 8);
        total++; if (rx_timeout) begin bad++; $display("FAIL bp_timeout got=%0d beats exp=8", rx_n); end
        for (int i = 0; i < 8; i++) begin
            total++; if (rx_data[i] !== 32'(300 + i)) begin bad++; $display("FAIL bp_beat%0d got=%0d exp=%0d", i, rx_data[i], 300 + i); end
        end
        total++; if (rx_stall_bad !== 0) begin bad++; $display("FAIL bp_stable got=%0d unstable stalls exp=0", rx_stall_bad); end
        total++; if (rx_last_cnt !== 1 || rx_last_idx !== 7) begin bad++; $display("FAIL bp_tlast got cnt=%0d idx=%0d exp cnt=1 idx=7", rx_last_cnt, rx_last_idx); end
        total++; if (sts_state !== 2'd0) begin bad++; $display("FAIL bp_idle got=%0d exp=0", sts_state); end
    endtask

    task automatic test_ignored();
        for (int i = 0; i < 3; i++) send(32'(50 + i), 1'b1, 0);
        total++; if (sts_state !== 2'd0) begin bad++; $display("FAIL ign_idle_trig got=%0d exp=0", sts_state); end
        total++; if (sts_first !== 32'd300) begin bad++; $display("FAIL ign_idle_first got=%0d exp=300", sts_first); end
        arm();
        send(32'd400, 1'b1, 0);
        send(32'd401, 1'b0, 0);
        cfg_arm = 1'b1;
        send(32'd402, 1'b1, 0);
        cfg_arm = 1'b0;
        total++; if (sts_state !== 2'd2) begin bad++; $display("FAIL ign_cap_state got=%0d exp=2", sts_state); end
        total++; if (sts_first !== 32'd400) begin bad++; $display("FAIL ign_cap_first got=%0d exp=400", sts_first); end
        for (int i = 3; i < 8; i++) send(32'(400 + i), 1'b0, 0);
        fork
            collect(1'b0, 8);
            begin
                tick(); tick();
                cfg_arm = 1'b1; trig_flag = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 32'd999;
                tick();
                cfg_arm = 1'b0; trig_flag = 1'b0; s_axis_tvalid = 1'b0;
                total++; if (sts_state !== 2'd3) begin bad++; $display("FAIL ign_rd_state got=%0d exp=3", sts_state); end
            end
        join
        total++; if (rx_timeout) begin bad++; $display("FAIL ign_timeout got=%0d beats exp=8", rx_n); end
        for (int i = 0; i < 8; i++) begin
            total++; if (rx_data[i] !== 32'(400 + i)) begin bad++; $display("FAIL ign_beat%0d got=%0d exp=%0d", i, rx_data[i], 400 + i); end
        end
        total++; if (sts_first !== 32'd400) begin bad++; $display("FAIL ign_rd_first got=%0d exp=400", sts_first); end
        total++; if (sts_state !== 2'd0) begin bad++; $display("FAIL ign_idle got=%0d exp=0", sts_state); end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        arm();
        for (int i = 0; i < 8; i++) send(32'(500 + i), (i == 0), 0);
        collect(1'b0, 3);
        total++; if (rx_n !== 3) begin bad++; $display("FAIL rst_pre_beats got=%0d exp=3", rx_n); end
        aresetn = 1'b0;
        #1;
        total++; if (sts_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", sts_state); end
        total++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_valid_last got=%0b%0b exp=00", m_axis_tvalid, m_axis_tlast); end
        total++; if (m_axis_tdata !== 32'd0) begin bad++; $display("FAIL rst_tdata got=%0d exp=0", m_axis_tdata); end
        total++; if (sts_first !== 32'd0) begin bad++; $display("FAIL rst_first got=%0d exp=0", sts_first); end
        tick(); tick();
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (m_axis_tvalid) stray++;
            tick();
        end
        m_axis_tready = 1'b0;
        total++; if (stray !== 0) begin bad++; $display("FAIL rst_no_beats got=%0d exp=0", stray); end
        arm();
        for (int i = 0; i < 8; i++) send(32'(600 + i), (i == 0), 0);
        collect(1'b0, 8);
        total++; if (rx_timeout) begin bad++; $display("FAIL rst_re_timeout got=%0d beats exp=8", rx_n); end
        for (int i = 0; i < 8; i++) begin
            total++; if (rx_data[i] !== 32'(600 + i)) begin bad++; $display("FAIL rst_re_beat%0d got=%0d exp=%0d", i, rx_data[i], 600 + i); end
        end
        total++; if (rx_last_idx !== 7) begin bad++; $display("FAIL rst_re_tlast got=%0d exp=7", rx_last_idx); end
    endtask

`ifdef AXIS_SNAPSHOT_PRETRIG_EN
    task automatic test_pretrig();
        cfg_pretrig = 3'd3;
        arm();
        send(32'd115, 1'b0, 0);
        send(32'd116, 1'b0, 0);
        send(32'd117, 1'b1, 0);
        total++; if (sts_state !== 2'd1) begin bad++; $display("FAIL pre_early_trig got=%0d exp=1", sts_state); end
        send(32'd118, 1'b0, 0);
        send(32'd119, 1'b0, 0);
        send(32'd120, 1'b1, 0);
        total++; if (sts_state !== 2'd2) begin bad++; $display("FAIL pre_capture got=%0d exp=2", sts_state); end
        total++; if (sts_first !== 32'd120) begin bad++; $display("FAIL pre_first got=%0d exp=120", sts_first); end
        for (int i = 121; i <= 124; i++) send(32'(i), 1'b0, 0);
        total++; if (sts_state !== 2'd3) begin bad++; $display("FAIL pre_readout got=%0d exp=3", sts_state); end
        collect(1'b0, 8);
        total++; if (rx_timeout) begin bad++; $display("FAIL pre_timeout got=%0d beats exp=8", rx_n); end
        for (int i = 0; i < 8; i++) begin
            total++; if (rx_data[i] !== 32'(117 + i)) begin bad++; $display("FAIL pre_beat%0d got=%0d exp=%0d", i, rx_data[i], 117 + i); end
        end
        total++; if (rx_last_idx !== 7) begin bad++; $display("FAIL pre_tlast got=%0d exp=7", rx_last_idx); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_ignored();
        test_reset_mid();
`ifdef AXIS_SNAPSHOT_PRETRIG_EN
        test_pretrig();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
